// File: rtl/mem_ref_exec_unit.sv
// mem_ref_exec_unit: multi-cycle executor for accumulator memory-reference
// instructions (Load, Store, Add, Subt, Clear, AddI). Owns AC, MAR and MBR and
// sequences operand fetch / write-back over a req/ack handshake with timeout.
module mem_ref_exec_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] ac,
    output logic              ovf,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // Opcode encodings as issued by the decoder.
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUBT  = 4'h4;
    localparam logic [3:0] OP_CLEAR = 4'hA;
    localparam logic [3:0] OP_ADDI  = 4'hB;

    // The wait counter never exceeds TIMEOUT-1: reaching that value without
    // an ack ends the request, so $clog2(TIMEOUT) bits suffice.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_PTR,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          op_reg;
    logic [ADDR_W-1:0]   mar_reg;
    logic [DATA_W-1:0]   mbr_reg;
    logic [DATA_W-1:0]   ac_reg, ac_next;
    logic                ovf_reg, ovf_next;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic                err_reg;

    logic                mem_cycle;
    logic                timed_out;
    logic                op_legal;
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   diff;
    logic                sum_ovf;
    logic                diff_ovf;

    // Decode whether the presented opcode is one we execute.
    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUBT, OP_CLEAR, OP_ADDI: op_legal = 1'b1;
            default:                                               op_legal = 1'b0;
        endcase
    end

    // Handshake status: a request is outstanding in PTR/READ/WRITE, and it
    // times out on its TIMEOUT-th cycle if that cycle also lacks an ack.
    always_comb begin
        mem_cycle = (state_reg == S_PTR) || (state_reg == S_READ) || (state_reg == S_WRITE);
        timed_out = mem_cycle && !mem_ack && (wait_cnt_reg == CNT_LAST);
    end

    // Modulo arithmetic with two's-complement overflow detection: addition
    // overflows when both operands share a sign that the result lacks;
    // subtraction overflows when the operands differ in sign and the result
    // sign differs from the minuend.
    always_comb begin
        sum      = ac_reg + mbr_reg;
        diff     = ac_reg - mbr_reg;
        sum_ovf  = (ac_reg[DATA_W-1] == mbr_reg[DATA_W-1]) &&
                   (sum[DATA_W-1] != ac_reg[DATA_W-1]);
        diff_ovf = (ac_reg[DATA_W-1] != mbr_reg[DATA_W-1]) &&
                   (diff[DATA_W-1] != ac_reg[DATA_W-1]);
    end

    // Accumulator and overflow update, applied only in the EXEC cycle.
    always_comb begin
        ac_next  = ac_reg;
        ovf_next = ovf_reg;
        if (state_reg == S_EXEC) begin
            case (op_reg)
                OP_LOAD: begin
                    ac_next  = mbr_reg;
                    ovf_next = 1'b0;
                end
                OP_ADD, OP_ADDI: begin
                    ac_next  = sum;
                    ovf_next = sum_ovf;
                end
                OP_SUBT: begin
                    ac_next  = diff;
                    ovf_next = diff_ovf;
                end
                OP_CLEAR: begin
                    ac_next  = '0;
                    ovf_next = 1'b0;
                end
                default: begin
                    ac_next  = ac_reg;
                    ovf_next = ovf_reg;
                end
            endcase
        end
    end

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != S_IDLE);
        done       = (state_reg == S_DONE);
        error      = (state_reg == S_DONE) && err_reg;
        mem_req    = mem_cycle;
        mem_we     = (state_reg == S_WRITE);
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_LOAD, OP_ADD, OP_SUBT: state_next = S_READ;
                        OP_ADDI:                  state_next = S_PTR;
                        OP_STORE:                 state_next = S_WRITE;
                        OP_CLEAR:                 state_next = S_EXEC;
                        default:                  state_next = S_DONE;
                    endcase
                end
            end
            S_PTR: begin
                if (mem_ack) begin
                    state_next = S_READ;
                end else if (timed_out) begin
                    state_next = S_DONE;
                end
            end
            S_READ: begin
                if (mem_ack) begin
                    state_next = S_EXEC;
                end else if (timed_out) begin
                    state_next = S_DONE;
                end
            end
            S_WRITE: begin
                if (mem_ack || timed_out) begin
                    state_next = S_DONE;
                end
            end
            S_EXEC:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers: operand capture, pointer chase, wait counting and
    // the sticky abort flag reported alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg       <= '0;
            mar_reg      <= '0;
            mbr_reg      <= '0;
            ac_reg       <= '0;
            ovf_reg      <= 1'b0;
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            ac_reg  <= ac_next;
            ovf_reg <= ovf_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg       <= op;
                        mar_reg      <= addr;
                        wait_cnt_reg <= '0;
                        err_reg      <= !op_legal;
                    end
                end
                S_PTR: begin
                    if (mem_ack) begin
                        // Indirect: the fetched word becomes the operand address.
                        mar_reg      <= mem_rdata[ADDR_W-1:0];
                        wait_cnt_reg <= '0;
                    end else if (timed_out) begin
                        err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        mbr_reg <= mem_rdata;
                    end else if (timed_out) begin
                        err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        wait_cnt_reg <= '0;
                    end else if (timed_out) begin
                        err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    wait_cnt_reg <= wait_cnt_reg;
                end
            endcase
        end
    end

    // Memory address and write data come straight from MAR and AC so they
    // stay stable for the whole request.
    assign mem_addr  = mar_reg;
    assign mem_wdata = ac_reg;
    assign ac        = ac_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_mem_ref_exec_unit.sv
// Testbench for mem_ref_exec_unit: table-driven instruction vectors with a
// scoreboard queue, a behavioural memory with programmable ack delay, and
// hand-written sequences for reset-abort, delayed store and timeout.
module tb_mem_ref_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op_i = 4'h0;
    logic [13:0] addr_i = '0;
    logic        busy, done, error, ovf, mem_req, mem_we;
    logic [15:0] ac, mem_wdata;
    logic [13:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    mem_ref_exec_unit #(.DATA_W(16), .ADDR_W(14), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op_i),
        .addr      (addr_i),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .ac        (ac),
        .ovf       (ovf),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [13:0] addr;
        logic [13:0] pa;
        logic [15:0] pd;
        logic [13:0] pb;
        logic [15:0] pdb;
        int          dly;
        bit          noack;
        logic [15:0] exp_ac;
        logic        exp_ovf;
        logic        exp_err;
        int          exp_lat;
        int          exp_req;
    } vec_t;

    logic [15:0] mem_model [0:16383];
    int          ack_delay = 0;
    bit          no_ack = 1'b0;
    int          wcnt = 0;

    int checks = 0;
    int errors = 0;

    vec_t sb_q[$];
    int   req_n, we_n, wd_n, ad_n;

    // Memory responder: acks after ack_delay wait cycles; a new request is
    // recognised whenever the previous cycle carried an ack.
    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else begin
            if (mem_ack) wcnt = 0;
            if (!no_ack && wcnt == ack_delay) begin
                mem_ack = 1'b1;
                mem_rdata = mem_model[mem_addr];
                if (mem_we) mem_model[mem_addr] = mem_wdata;
            end else begin
                mem_ack = 1'b0;
                wcnt = wcnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [13:0] addr,
                                input logic [13:0] pa, input logic [15:0] pd,
                                input logic [13:0] pb, input logic [15:0] pdb,
                                input int dly, input bit noack,
                                input logic [15:0] eac, input logic eovf, input logic eerr,
                                input int elat, input int ereq);
        vec_t v;
        v.op = op; v.addr = addr; v.pa = pa; v.pd = pd; v.pb = pb; v.pdb = pdb;
        v.dly = dly; v.noack = noack; v.exp_ac = eac; v.exp_ovf = eovf;
        v.exp_err = eerr; v.exp_lat = elat; v.exp_req = ereq;
        return v;
    endfunction

    // Issue one instruction, wait (bounded) for done, compare against the
    // scoreboard entry. pulse=1 also pulses start while the unit is busy.
    task automatic run_op(input vec_t v, input bit pulse);
        vec_t e;
        int   n;
        bit   got;
        mem_model[v.pa] = v.pd;
        mem_model[v.pb] = v.pdb;
        ack_delay = v.dly;
        no_ack = v.noack;
        sb_q.push_back(v);
        @(negedge clk);
        op_i = v.op;
        addr_i = v.addr;
        start = 1'b1;
        n = 0; got = 1'b0;
        req_n = 0; we_n = 0; wd_n = 0; ad_n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (pulse && n == 2) begin
                start = 1'b1;
                op_i = 4'h1;
                addr_i = 14'h0000;
            end
            if (pulse && n == 3) start = 1'b0;
            if (mem_req) begin
                req_n++;
                if (mem_we) we_n++;
                if (mem_wdata == v.exp_ac) wd_n++;
                if (mem_addr == v.addr) ad_n++;
            end
            if (done) got = 1'b1;
        end
        e = sb_q.pop_front();
        if (!got) begin
            chk("done_wait", 32'd0, 32'd1);
        end else begin
            chk("ac", 32'(ac), 32'(e.exp_ac));
            chk("ovf", 32'(ovf), 32'(e.exp_ovf));
            chk("error", 32'(error), 32'(e.exp_err));
            chk("latency", 32'(n), 32'(e.exp_lat));
            chk("req_cycles", 32'(req_n), 32'(e.exp_req));
        end
        $display("op=%h addr=%h ac=%h ovf=%0d err=%0d lat=%0d req=%0d",
                 v.op, v.addr, ac, ovf, error, n, req_n);
    endtask

    vec_t tbl[13];
    int   done_seen;

    initial begin
        for (int i = 0; i < 16384; i++) mem_model[i] = 16'h0000;

        tbl[0]  = mk(4'h1, 14'h100, 14'h100, 16'h7FFF, 14'h100, 16'h7FFF, 0, 0, 16'h7FFF, 0, 0, 3, 1);
        tbl[1]  = mk(4'h3, 14'h101, 14'h101, 16'h0001, 14'h101, 16'h0001, 0, 0, 16'h8000, 1, 0, 3, 1);
        tbl[2]  = mk(4'h4, 14'h101, 14'h101, 16'h0001, 14'h101, 16'h0001, 0, 0, 16'h7FFF, 1, 0, 3, 1);
        tbl[3]  = mk(4'h3, 14'h102, 14'h102, 16'h0002, 14'h102, 16'h0002, 0, 0, 16'h8001, 1, 0, 3, 1);
        tbl[4]  = mk(4'h7, 14'h000, 14'h3000, 16'h0000, 14'h3000, 16'h0000, 0, 0, 16'h8001, 1, 1, 1, 0);
        tbl[5]  = mk(4'h1, 14'h103, 14'h103, 16'h0005, 14'h103, 16'h0005, 0, 0, 16'h0005, 0, 0, 3, 1);
        tbl[6]  = mk(4'hA, 14'h000, 14'h3000, 16'h0000, 14'h3000, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 0);
        tbl[7]  = mk(4'h1, 14'h104, 14'h104, 16'h000A, 14'h104, 16'h000A, 0, 0, 16'h000A, 0, 0, 3, 1);
        tbl[8]  = mk(4'hB, 14'h020, 14'h020, 16'h0030, 14'h030, 16'h0005, 0, 0, 16'h000F, 0, 0, 4, 2);
        tbl[9]  = mk(4'h4, 14'h105, 14'h105, 16'h0010, 14'h105, 16'h0010, 0, 0, 16'hFFFF, 0, 0, 3, 1);
        tbl[10] = mk(4'h3, 14'h106, 14'h106, 16'h8000, 14'h106, 16'h8000, 0, 0, 16'h7FFF, 1, 0, 3, 1);
        tbl[11] = mk(4'h1, 14'h107, 14'h107, 16'hBEEF, 14'h107, 16'hBEEF, 0, 0, 16'hBEEF, 0, 0, 3, 1);
        tbl[12] = mk(4'h1, 14'h108, 14'h108, 16'h4321, 14'h108, 16'h4321, 0, 0, 16'h4321, 0, 0, 3, 1);

        // Reset state.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_ac", 32'(ac), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        $display("reset: busy=%0d ac=%h mem_req=%0d", busy, ac, mem_req);

        // First Load, zero-wait.
        run_op(mk(4'h1, 14'h010, 14'h010, 16'h1234, 14'h010, 16'h1234, 0, 0, 16'h1234, 0, 0, 3, 1), 1'b0);

        // Reset in the middle of READ: request drops at once, no done.
        no_ack = 1'b1;
        @(negedge clk);
        op_i = 4'h1; addr_i = 14'h010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midrd_req_before", 32'(mem_req), 1);
        #2 reset = 1'b1;
        #1;
        chk("midrd_req_after", 32'(mem_req), 0);
        chk("midrd_busy", 32'(busy), 0);
        chk("midrd_ac", 32'(ac), 0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("midrd_no_done", 32'(done_seen), 0);
        $display("reset mid-READ: mem_req=%0d ac=%h done_seen=%0d", mem_req, ac, done_seen);
        no_ack = 1'b0;

        // Table of back-to-back instructions.
        for (int i = 0; i < 12; i++) run_op(tbl[i], 1'b0);

        // Store to top address, ack after 3 wait cycles, start pulsed while busy.
        run_op(mk(4'h2, 14'h3FFF, 14'h3000, 16'h0000, 14'h3000, 16'h0000, 3, 0, 16'hBEEF, 0, 0, 5, 4), 1'b1);
        chk("store_we_cycles", 32'(we_n), 4);
        chk("store_wdata_cycles", 32'(wd_n), 4);
        chk("store_addr_cycles", 32'(ad_n), 4);
        chk("store_mem", 32'(mem_model[14'h3FFF]), 32'h0000BEEF);
        @(negedge clk);
        chk("store_idle_after", 32'(busy), 0);
        chk("store_pulse_ignored_ac", 32'(ac), 32'h0000BEEF);

        // Add whose ack never comes: 15 request cycles, abort with error.
        run_op(mk(4'h3, 14'h200, 14'h200, 16'h0001, 14'h200, 16'h0001, 0, 1, 16'hBEEF, 0, 1, 16, 15), 1'b0);

        // Normal operation resumes after the timeout.
        run_op(tbl[12], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard against a hung simulation.
    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
